scan_seq_ctrl: RTL and testbench

SCAN_SEQ_CTRL -- requirements
Module: scan_seq_ctrl

---
 rtl/scan_ctrl_pkg.sv | 29 ++
 rtl/scan_misr.sv | 38 +++
 rtl/scan_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_scan_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl_pkg.sv
// ============================================================================
// Module      : scan_ctrl_pkg
// Description : Shared state encoding and MISR constants for the scan controller
// Revision    : 1.0
// ============================================================================
`default_nettype none

package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CAPTURE = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int                  C_MISR_W    = 16;
  localparam logic [C_MISR_W-1:0] C_MISR_POLY = 16'h1021;

  // One signature update: shift left, fold in the polynomial on carry-out, xor the new bit.
  function automatic logic [C_MISR_W-1:0] misr_step(input logic [C_MISR_W-1:0] sig,
                                                    input logic                 din);
    return (sig << 1) ^ (sig[C_MISR_W-1] ? C_MISR_POLY : '0) ^ {{(C_MISR_W-1){1'b0}}, din};
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_misr.sv
// ============================================================================
// Module      : scan_misr
// Description : 16-bit response-compaction register; exists only when the
//               SCAN_MISR_EN macro is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifdef SCAN_MISR_EN
module scan_misr
  import scan_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_clear,
  input  logic                i_en,
  input  logic                i_din,
  output logic [C_MISR_W-1:0] o_sig
);

  logic [C_MISR_W-1:0] r_sig;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sig <= '0;
    end else if (i_clear) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= misr_step(r_sig, i_din);
    end
  end

  assign o_sig = r_sig;

endmodule
`endif

`default_nettype wire

// File: rtl/scan_seq_ctrl.sv
// ============================================================================
// Module      : scan_seq_ctrl
// Description : Scan test sequencer: shift / capture / flush of one scan chain.
//               Optional response signature enabled by macro SCAN_MISR_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module scan_seq_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 4,
  parameter int NPAT_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NPAT_W-1:0] num_pat,
  input  logic              si_data,
  input  logic              si_valid,
  output logic              si_ready,
  input  logic              scan_out,
  output logic              scan_en,
  output logic              scan_in,
  output logic              func_en,
  output logic              so_data,
  output logic              so_valid,
  output logic              busy,
  output logic              done,
  output logic [NPAT_W-1:0] pat_cnt
`ifdef SCAN_MISR_EN
  ,
  output logic [C_MISR_W-1:0] signature
`endif
);

  localparam int               C_BIT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [C_BIT_W-1:0] C_LAST = C_BIT_W'(CHAIN_LEN - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [C_BIT_W-1:0]  r_bit;
  logic [C_BIT_W-1:0]  w_bit_nxt;
  logic [NPAT_W-1:0]   r_pat;
  logic [NPAT_W-1:0]   w_pat_nxt;
  logic [NPAT_W-1:0]   r_npat;
  logic [NPAT_W-1:0]   w_npat_nxt;
  logic [NPAT_W-1:0]   w_pat_inc;

  assign w_pat_inc = r_pat + NPAT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_pat   <= '0;
      r_npat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_pat   <= w_pat_nxt;
      r_npat  <= w_npat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_pat_nxt   = r_pat;
    w_npat_nxt  = r_npat;
    si_ready    = 1'b0;
    scan_en     = 1'b0;
    scan_in     = 1'b0;
    func_en     = 1'b0;
    so_valid    = 1'b0;
    done        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_npat_nxt  = num_pat;
          w_pat_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = (num_pat == '0) ? S_DONE : S_SHIFT;
        end
      end

      S_SHIFT: begin
        si_ready = 1'b1;
        // Without valid data the chain simply holds; nothing advances.
        if (si_valid) begin
          scan_en  = 1'b1;
          scan_in  = si_data;
          so_valid = (r_pat != '0);
          if (r_bit == C_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_CAPTURE;
          end else begin
            w_bit_nxt = r_bit + C_BIT_W'(1);
          end
        end
      end

      S_CAPTURE: begin
        func_en     = 1'b1;
        w_pat_nxt   = w_pat_inc;
        w_state_nxt = (w_pat_inc == r_npat) ? S_FLUSH : S_SHIFT;
      end

      S_FLUSH: begin
        // Unload the last response with zeros shifted in behind it.
        scan_en  = 1'b1;
        so_valid = 1'b1;
        if (r_bit == C_LAST) begin
          w_bit_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_bit_nxt = r_bit + C_BIT_W'(1);
        end
      end

      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy    = (r_state != S_IDLE);
  assign so_data = so_valid & scan_out;
  assign pat_cnt = r_pat;

`ifdef SCAN_MISR_EN
  logic w_misr_clr;

  assign w_misr_clr = (r_state == S_IDLE) && start;

  scan_misr u_misr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_misr_clr),
    .i_en    (so_valid),
    .i_din   (so_data),
    .o_sig   (signature)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_scan_seq_ctrl.sv
// ============================================================================
// Module      : tb_scan_seq_ctrl
// Description : Self-checking bench for scan_seq_ctrl (signature checks when
//               SCAN_MISR_EN is defined).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_scan_seq_ctrl;

  localparam int L  = 4;
  localparam int NW = 8;

  localparam int P_IDLE = 0, P_SHIFT = 1, P_CAP = 2, P_FLUSH = 3, P_DONE = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [NW-1:0] num_pat;
  logic          si_data;
  logic          si_valid;
  logic          si_ready;
  logic          scan_out;
  logic          scan_en;
  logic          scan_in;
  logic          func_en;
  logic          so_data;
  logic          so_valid;
  logic          busy;
  logic          done;
  logic [NW-1:0] pat_cnt;
`ifdef SCAN_MISR_EN
  logic [15:0]   signature;
`endif

  scan_seq_ctrl #(.CHAIN_LEN(L), .NPAT_W(NW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .num_pat  (num_pat),
    .si_data  (si_data),
    .si_valid (si_valid),
    .si_ready (si_ready),
    .scan_out (scan_out),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .func_en  (func_en),
    .so_data  (so_data),
    .so_valid (so_valid),
    .busy     (busy),
    .done     (done),
    .pat_cnt  (pat_cnt)
`ifdef SCAN_MISR_EN
    ,
    .signature(signature)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Run-level model: progress is tracked as counts of shift steps, captures and flush cycles.
  int          m_active, m_n, m_steps, m_caps, m_flush;
  logic [15:0] m_sig;
  logic        e_so_valid, e_so_data;

  int rec_t, rec_se, rec_fe, rec_sov, rec_done_t;
  int rec_ft [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int phase();
    if (m_active == 0)                         return P_IDLE;
    if (m_caps == m_n && m_flush == L)         return P_DONE;
    if (m_steps == (m_caps + 1) * L)           return P_CAP;
    if (m_caps == m_n)                         return P_FLUSH;
    return P_SHIFT;
  endfunction

  task automatic model_reset();
    m_active = 0; m_n = 0; m_steps = 0; m_caps = 0; m_flush = 0; m_sig = '0;
  endtask

  task automatic compare();
    int   p;
    logic step;
    p    = phase();
    step = (p == P_SHIFT) && si_valid;
    e_so_valid = (step && m_caps > 0) || (p == P_FLUSH);
    e_so_data  = e_so_valid & scan_out;
    chk("busy",     busy,     p != P_IDLE);
    chk("si_ready", si_ready, p == P_SHIFT);
    chk("scan_en",  scan_en,  step || p == P_FLUSH);
    chk("scan_in",  scan_in,  step & si_data);
    chk("func_en",  func_en,  p == P_CAP);
    chk("so_valid", so_valid, e_so_valid);
    chk("so_data",  so_data,  e_so_data);
    chk("done",     done,     p == P_DONE);
    chk("pat_cnt",  pat_cnt,  m_caps);
`ifdef SCAN_MISR_EN
    chk("signature", signature, m_sig);
`endif
    if (scan_en)  rec_se++;
    if (so_valid) rec_sov++;
    if (func_en) begin
      if (rec_fe < 2) rec_ft[rec_fe] = rec_t;
      rec_fe++;
    end
    if (done && rec_done_t < 0) rec_done_t = rec_t;
    rec_t++;
  endtask

  task automatic model_update();
    int p;
    if (!reset_n) begin
      model_reset();
      return;
    end
    p = phase();
    if (e_so_valid) m_sig = (m_sig << 1) ^ (m_sig[15] ? 16'h1021 : 16'h0) ^ {15'd0, e_so_data};
    case (p)
      P_IDLE: if (start) begin
        m_active = 1; m_n = int'(num_pat); m_steps = 0; m_caps = 0; m_sig = '0;
        m_flush  = (m_n == 0) ? L : 0;
      end
      P_SHIFT: if (si_valid) m_steps++;
      P_CAP:   m_caps++;
      P_FLUSH: m_flush++;
      default: m_active = 0;
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    compare();
    tick();
    reset_n = 1'b1;
  endtask

  // Directed run from idle; times are counted in cycles from the start cycle t0.
  task automatic directed(input int n, input int stall_at, input bit hold_start,
                          input int so_fix, input int nt);
    start = 1'b0; si_valid = 1'b1;
    for (int k = 0; k < 200 && m_active != 0; k++) tick();
    chk("idle_before_run", busy, 1'b0);
    rec_t = 0; rec_se = 0; rec_fe = 0; rec_sov = 0; rec_done_t = -1;
    rec_ft[0] = -1; rec_ft[1] = -1;
    start = 1'b1; num_pat = NW'(n); si_data = 1'($urandom);
    scan_out = (so_fix < 0) ? 1'($urandom) : 1'(so_fix);
    tick();
    for (int t = 1; t < nt; t++) begin
      start    = hold_start && (t < 14);
      num_pat  = hold_start ? NW'(7) : NW'(n);
      si_valid = !((t >= stall_at) && (t < stall_at + 3));
      si_data  = 1'($urandom);
      scan_out = (so_fix < 0) ? 1'($urandom) : 1'(so_fix);
      tick();
    end
    start = 1'b0;
    si_valid = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; num_pat = '0;
    si_data = 1'b0; si_valid = 1'b0; scan_out = 1'b0;
    model_reset();
    e_so_valid = 1'b0; e_so_data = 1'b0;
    rec_t = 0; rec_se = 0; rec_fe = 0; rec_sov = 0; rec_done_t = -1;
    #1;
    compare();
    chk("reset_busy", busy, 1'b0);
    chk("reset_scan_en", scan_en, 1'b0);
    tick();
    reset_n = 1'b1;

    // Start is taken on the very first edge after reset release.
    start = 1'b1; num_pat = 8'd1; si_valid = 1'b1;
    tick();
    chk("start_first_edge", busy, 1'b1);
    start = 1'b0;

    // Two patterns, start held high (and num_pat changed) while busy.
    directed(2, -10, 1'b1, -1, 20);
    chk("p2_done_t",  rec_done_t, 15);
    chk("p2_scan_en", rec_se, 12);
    chk("p2_func_n",  rec_fe, 2);
    chk("p2_func_t0", rec_ft[0], 5);
    chk("p2_func_t1", rec_ft[1], 10);
    chk("p2_so_valid", rec_sov, 8);
    chk("p2_pat_cnt", pat_cnt, 8'd2);

    // Three-cycle stall in the first shift pass.
    directed(2, 3, 1'b0, -1, 24);
    chk("stall_done_t",  rec_done_t, 18);
    chk("stall_scan_en", rec_se, 12);
    chk("stall_so_valid", rec_sov, 8);

    // Zero patterns.
    directed(0, -10, 1'b0, -1, 4);
    chk("zero_done_t",  rec_done_t, 1);
    chk("zero_scan_en", rec_se, 0);
    chk("zero_pat_cnt", pat_cnt, 8'd0);

    // Reset asserted in the middle of FLUSH.
    start = 1'b1; num_pat = 8'd1; si_valid = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 50 && phase() != P_FLUSH; k++) tick();
    tick();
    async_reset();
    chk("flush_rst_busy",    busy, 1'b0);
    chk("flush_rst_pat_cnt", pat_cnt, 8'd0);
    directed(1, -10, 1'b0, -1, 12);
    chk("after_rst_done_t", rec_done_t, 10);
    chk("after_rst_pat_cnt", pat_cnt, 8'd1);

`ifdef SCAN_MISR_EN
    directed(1, -10, 1'b0, 1, 12);
    chk("misr_sig", signature, 16'h000F);
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      start    = ($urandom_range(0, 3) == 0);
      num_pat  = NW'($urandom_range(0, 6));
      si_valid = ($urandom_range(0, 3) != 0);
      si_data  = 1'($urandom);
      scan_out = 1'($urandom);
      if ($urandom_range(0, 399) == 0) async_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
